lc3_mem_port_arbiter: RTL

- Parametrised N-channel arbiter that lets several LC3 requesters (fetch imem port, memaccess dmem port, and later a debug/DMA port) share one fixed-latency synchronous memory.
- Sits between the pipeline stages and the unified memory model.
- Generalises the two fixed imem/dmem paths to NUM_CH channels, with selectable round-robin/fixed priority, a grant-hold limit and pipelined response routing.

---
 rtl/lc3_mem_port_arbiter_pkg.sv | 17 +
 rtl/lc3_mem_port_arbiter_if.sv | 30 +++
 rtl/lc3_mem_port_arbiter_rr_picker.sv | 47 ++++
 rtl/lc3_mem_port_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/lc3_mem_port_arbiter_pkg.sv
// Shared types for the LC3 memory-port arbiter and its grant picker.
// Channel ids are sized for the largest supported channel count (8).
package lc3_mem_arb_pkg;
    localparam int CH_W       = 3;
    localparam int HOLD_W     = 8;
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef logic [CH_W-1:0]   chan_id_t;
    typedef logic [HOLD_W-1:0] hold_cnt_t;

    typedef struct packed {
        logic     valid;
        chan_id_t id;
        logic     we;
    } rsp_stage_t;
endpackage

// File: rtl/lc3_mem_port_arbiter_if.sv
// Request, response and memory-side signals of the LC3 memory-port arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface lc3_mem_port_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        req_we;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     mem_en;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_din;
    logic [DATA_W-1:0]        mem_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/lc3_mem_port_arbiter_rr_picker.sv
// Combinational grant picker: round-robin with grant-hold limit, or fixed priority.
// Zero latency; returns a one-hot grant (or zero) plus the winner index.
module lc3_rr_picker
    import lc3_mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int HOLD_MAX = 1
) (
    input  logic [NUM_CH-1:0] valid_i,
    input  chan_id_t          last_grant_i,
    input  hold_cnt_t         hold_cnt_i,
    input  logic              fixed_mode_i,
    output logic [NUM_CH-1:0] grant_o,
    output chan_id_t          winner_o,
    output logic              any_o
);
    int   d;
    int   best_d;
    logic keep;

    // d is the priority distance: the valid channel with the smallest d wins.
    always_comb begin
        winner_o = '0;
        grant_o  = '0;
        best_d   = NUM_CH + 1;
        d        = 0;
        keep     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (fixed_mode_i) begin
                d = i + 1;
            end else begin
                d = (i + NUM_CH - int'(last_grant_i)) % NUM_CH;
                if (d == 0) d = NUM_CH;
                if (valid_i[i] && int'(last_grant_i) == i && int'(hold_cnt_i) < HOLD_MAX)
                    keep = 1'b1;
            end
            if (valid_i[i] && d < best_d) begin
                best_d   = d;
                winner_o = chan_id_t'(i);
            end
        end
        if (keep) winner_o = last_grant_i;
        any_o = (best_d <= NUM_CH);
        for (int i = 0; i < NUM_CH; i++)
            grant_o[i] = any_o && (int'(winner_o) == i);
    end
endmodule

// File: rtl/lc3_mem_port_arbiter.sv
// N-channel arbiter sharing one fixed-latency memory; response strobe MEM_LAT+1 cycles after issue.
// Requests stall via req_ready; responses have no back-pressure and must be accepted.
module lc3_mem_port_arbiter
    import lc3_mem_arb_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 1,
    parameter int PRIO_MODE = 0,
    parameter int HOLD_MAX  = 1
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    lc3_mem_port_arbiter_if.slave   bus,
    output logic                    busy_o
);
    logic [NUM_CH-1:0] pick_grant;
    chan_id_t          pick_id;
    logic              pick_any;
    logic              issue;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;

    chan_id_t          last_grant_q, last_grant_d;
    hold_cnt_t         hold_cnt_q, hold_cnt_d;
    rsp_stage_t        stage_q [MEM_LAT];
    rsp_stage_t        stage_d [MEM_LAT];
    logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    lc3_rr_picker #(
        .NUM_CH   (NUM_CH),
        .HOLD_MAX (HOLD_MAX)
    ) u_picker (
        .valid_i      (bus.req_valid),
        .last_grant_i (last_grant_q),
        .hold_cnt_i   (hold_cnt_q),
        .fixed_mode_i (PRIO_MODE == PRIO_FIXED),
        .grant_o      (pick_grant),
        .winner_o     (pick_id),
        .any_o        (pick_any)
    );

    // Grant and memory mux are gated by reset so nothing reaches memory while it is held.
    always_comb begin
        issue    = pick_any && !reset_i;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (issue && pick_grant[i]) begin
                mem_we   = bus.req_we[i];
                mem_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                mem_din  = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        if (issue) begin
            last_grant_d = pick_id;
            if (pick_id == last_grant_q)
                hold_cnt_d = (int'(hold_cnt_q) >= HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
            else
                hold_cnt_d = hold_cnt_t'(1);
        end

        stage_d[0].valid = issue;
        stage_d[0].id    = pick_id;
        stage_d[0].we    = mem_we;
        for (int s = 1; s < MEM_LAT; s++)
            stage_d[s] = stage_q[s-1];

        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        if (stage_q[MEM_LAT-1].valid) begin
            for (int i = 0; i < NUM_CH; i++)
                rsp_valid_d[i] = (int'(stage_q[MEM_LAT-1].id) == i);
            rsp_rdata_d = stage_q[MEM_LAT-1].we ? '0 : bus.mem_dout;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            last_grant_q <= chan_id_t'(NUM_CH - 1);
            hold_cnt_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            for (int s = 0; s < MEM_LAT; s++)
                stage_q[s] <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            for (int s = 0; s < MEM_LAT; s++)
                stage_q[s] <= stage_d[s];
        end
    end

    always_comb begin
        busy_o = |rsp_valid_q;
        for (int s = 0; s < MEM_LAT; s++)
            busy_o = busy_o | stage_q[s].valid;
    end

    assign bus.req_ready = issue ? pick_grant : '0;
    assign bus.mem_en    = issue;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_din   = mem_din;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule
